// File: rtl/edge_history_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : edge_history_monitor_if
// Description : Bus bundle between a stimulus/consumer and edge_history_monitor:
//               sampled bus, control inputs and registered sampled-value flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface edge_history_monitor_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int c_MB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_PS_W = $clog2(DEPTH);

    logic                en;
    logic [WIDTH-1:0]    din;
    logic [c_MB_W-1:0]   mon_bit;
    logic [c_PS_W-1:0]   past_sel;
    logic                clr_cnt;
    logic [WIDTH-1:0]    rose;
    logic [WIDTH-1:0]    fell;
    logic                changed;
    logic                stable;
    logic [WIDTH-1:0]    past_val;
    logic                past_valid;
    logic [CNT_W-1:0]    stable_cnt;
    logic [CNT_W-1:0]    rise_cnt;
    logic [CNT_W-1:0]    fall_cnt;

    modport master (
        output en, din, mon_bit, past_sel, clr_cnt,
        input  rose, fell, changed, stable, past_val, past_valid,
               stable_cnt, rise_cnt, fall_cnt
    );

    modport slave (
        input  en, din, mon_bit, past_sel, clr_cnt,
        output rose, fell, changed, stable, past_val, past_valid,
               stable_cnt, rise_cnt, fall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/edge_history_monitor.sv
`default_nettype none
// ============================================================================
// Module      : edge_history_monitor
// Description : Registered equivalents of $rose/$fell/$changed/$stable/$past
//               on a WIDTH-bit bus, with saturating edge and stable-run counters.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_history_monitor #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    edge_history_monitor_if.slave bus
);
    localparam int                    c_FILL_W  = $clog2(DEPTH + 1);
    localparam logic [c_FILL_W-1:0]   c_DEPTH_F = c_FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]      c_CNT_MAX = '1;

    logic [DEPTH-1:0][WIDTH-1:0] r_hist;
    logic [DEPTH-1:0][WIDTH-1:0] w_hist_nxt;
    logic [c_FILL_W-1:0]         r_fill;
    logic [WIDTH-1:0]            r_rose;
    logic [WIDTH-1:0]            r_fell;
    logic                        r_changed;
    logic                        r_stable;
    logic [CNT_W-1:0]            r_stable_cnt;
    logic [CNT_W-1:0]            r_rise_cnt;
    logic [CNT_W-1:0]            r_fall_cnt;

    logic                        w_primed;
    logic [WIDTH-1:0]            w_rose_nxt;
    logic [WIDTH-1:0]            w_fell_nxt;
    logic                        w_same;
    logic                        w_mon_rise;
    logic                        w_mon_fell;
    logic [WIDTH-1:0]            w_past_val;
    logic                        w_past_valid;

    // Edges are only meaningful once a previous sample exists.
    assign w_primed   = (r_fill != '0);
    assign w_rose_nxt = bus.din & ~r_hist[0];
    assign w_fell_nxt = ~bus.din & r_hist[0];
    assign w_same     = (bus.din == r_hist[0]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign w_hist_nxt[gi] = bus.din;
            end else begin : g_tail
                assign w_hist_nxt[gi] = r_hist[gi-1];
            end
        end
    endgenerate

    always_comb begin
        w_mon_rise = 1'b0;
        w_mon_fell = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (32'(bus.mon_bit) == i) begin
                w_mon_rise = w_rose_nxt[i];
                w_mon_fell = w_fell_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.en) begin
            r_hist <= w_hist_nxt;
            if (r_fill != c_DEPTH_F) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Flags are single-sample pulses: anything but a primed sample clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rose    <= '0;
            r_fell    <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b0;
        end else if (bus.en && w_primed) begin
            r_rose    <= w_rose_nxt;
            r_fell    <= w_fell_nxt;
            r_changed <= ~w_same;
            r_stable  <= w_same;
        end else begin
            r_rose    <= '0;
            r_fell    <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_stable_cnt <= '0;
            r_rise_cnt   <= '0;
            r_fall_cnt   <= '0;
        end else if (bus.en && w_primed) begin
            if (!w_same) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != c_CNT_MAX) begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end
            if (w_mon_rise && (r_rise_cnt != c_CNT_MAX)) begin
                r_rise_cnt <= r_rise_cnt + 1'b1;
            end
            if (w_mon_fell && (r_fall_cnt != c_CNT_MAX)) begin
                r_fall_cnt <= r_fall_cnt + 1'b1;
            end
        end
    end

    // Taps beyond DEPTH (non-power-of-2 DEPTH) match no entry and read as invalid.
    always_comb begin
        w_past_val   = '0;
        w_past_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((32'(bus.past_sel) == i) && (32'(r_fill) > i)) begin
                w_past_val   = r_hist[i];
                w_past_valid = 1'b1;
            end
        end
    end

    assign bus.rose       = r_rose;
    assign bus.fell       = r_fell;
    assign bus.changed    = r_changed;
    assign bus.stable     = r_stable;
    assign bus.past_val   = w_past_val;
    assign bus.past_valid = w_past_valid;
    assign bus.stable_cnt = r_stable_cnt;
    assign bus.rise_cnt   = r_rise_cnt;
    assign bus.fall_cnt   = r_fall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_edge_history_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_history_monitor
// Description : Directed plus random stimulus against a behavioural model,
//               expected outputs queued per edge and compared after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_history_monitor;
    localparam int c_W   = 4;
    localparam int c_D   = 4;
    localparam int c_CW  = 2;
    localparam int c_MAX = (1 << c_CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_history_monitor_if #(.WIDTH(c_W), .DEPTH(c_D), .CNT_W(c_CW)) bus ();

    edge_history_monitor #(.WIDTH(c_W), .DEPTH(c_D), .CNT_W(c_CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] rose;
        logic [3:0] fell;
        logic       changed;
        logic       stable;
        logic [3:0] past_val;
        logic       past_valid;
        logic [1:0] stable_cnt;
        logic [1:0] rise_cnt;
        logic [1:0] fall_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [3:0] m_hist [c_D];
    int         m_fill;
    logic [3:0] m_rose, m_fell;
    logic       m_chg, m_stb;
    int         m_sc, m_rc, m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] d,
                        input logic [1:0] mb, input logic [1:0] ps, input logic clr);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        rst = r; bus.en = e; bus.din = d; bus.mon_bit = mb; bus.past_sel = ps; bus.clr_cnt = clr;
        if (r) begin
            for (int i = 0; i < c_D; i++) m_hist[i] = 4'h0;
            m_fill = 0; m_rose = 4'h0; m_fell = 4'h0; m_chg = 1'b0; m_stb = 1'b0;
            m_sc = 0; m_rc = 0; m_fc = 0;
        end else begin
            if (e && m_fill > 0) begin
                m_rose = d & ~m_hist[0];
                m_fell = ~d & m_hist[0];
                m_chg  = (d != m_hist[0]);
                m_stb  = (d == m_hist[0]);
                m_sc   = m_stb ? ((m_sc < c_MAX) ? m_sc + 1 : c_MAX) : 0;
                if (m_rose[mb]) m_rc = (m_rc < c_MAX) ? m_rc + 1 : c_MAX;
                if (m_fell[mb]) m_fc = (m_fc < c_MAX) ? m_fc + 1 : c_MAX;
            end else begin
                m_rose = 4'h0; m_fell = 4'h0; m_chg = 1'b0; m_stb = 1'b0;
            end
            if (e) begin
                for (int i = c_D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = d;
                m_fill = (m_fill < c_D) ? m_fill + 1 : c_D;
            end
            if (clr) begin
                m_sc = 0; m_rc = 0; m_fc = 0;
            end
        end
        ex.rose       = m_rose;
        ex.fell       = m_fell;
        ex.changed    = m_chg;
        ex.stable     = m_stb;
        ex.past_valid = (m_fill > int'(ps));
        ex.past_val   = ex.past_valid ? m_hist[ps] : 4'h0;
        ex.stable_cnt = 2'(m_sc);
        ex.rise_cnt   = 2'(m_rc);
        ex.fall_cnt   = 2'(m_fc);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("rose",       32'(bus.rose),       32'(got.rose));
        chk("fell",       32'(bus.fell),       32'(got.fell));
        chk("changed",    32'(bus.changed),    32'(got.changed));
        chk("stable",     32'(bus.stable),     32'(got.stable));
        chk("past_val",   32'(bus.past_val),   32'(got.past_val));
        chk("past_valid", 32'(bus.past_valid), 32'(got.past_valid));
        chk("stable_cnt", 32'(bus.stable_cnt), 32'(got.stable_cnt));
        chk("rise_cnt",   32'(bus.rise_cnt),   32'(got.rise_cnt));
        chk("fall_cnt",   32'(bus.fall_cnt),   32'(got.fall_cnt));
    endtask

    initial begin
        bus.en = 1'b0; bus.din = 4'h0; bus.mon_bit = 2'd0; bus.past_sel = 2'd0; bus.clr_cnt = 1'b0;

        // Reset then bit0 toggle 0,1,1,0
        step(1, 0, 4'h0, 0, 0, 0);
        step(1, 0, 4'h0, 0, 0, 0);
        chk("rst_rise_cnt", 32'(bus.rise_cnt), 32'd0);
        chk("rst_past_valid", 32'(bus.past_valid), 32'd0);
        step(0, 1, 4'h0, 0, 0, 0);
        chk("t1_unprimed_rose", 32'(bus.rose), 32'h0);
        step(0, 1, 4'h1, 0, 0, 0);
        chk("t1_rose", 32'(bus.rose), 32'h1);
        chk("t1_rise_cnt", 32'(bus.rise_cnt), 32'd1);
        step(0, 1, 4'h1, 0, 0, 0);
        chk("t1_stable", 32'(bus.stable), 32'd1);
        chk("t1_stable_cnt", 32'(bus.stable_cnt), 32'd1);
        step(0, 1, 4'h0, 0, 0, 0);
        chk("t1_fell", 32'(bus.fell), 32'h1);
        chk("t1_fall_cnt", 32'(bus.fall_cnt), 32'd1);
        chk("t1_stable_cnt0", 32'(bus.stable_cnt), 32'd0);

        // Alternating 0100/0101 from a fresh history
        step(1, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, (i % 2) ? 4'h5 : 4'h4, 0, 0, 0);
            chk("alt_bit2_rose", 32'(bus.rose[2]), 32'd0);
        end
        chk("alt_rise_cnt", 32'(bus.rise_cnt), 32'd3);
        chk("alt_fall_cnt", 32'(bus.fall_cnt), 32'd2);

        // History taps
        step(1, 0, 4'h0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 4'(k), 0, 3, 0);
            if (k == 3) chk("tap3_valid_early", 32'(bus.past_valid), 32'd0);
        end
        chk("tap3_val", 32'(bus.past_val), 32'h2);
        chk("tap3_valid", 32'(bus.past_valid), 32'd1);
        step(0, 0, 4'h5, 0, 0, 0);
        chk("tap0_val", 32'(bus.past_val), 32'h5);

        // Enable gating, then re-enable against last enabled sample (5)
        step(0, 0, 4'h6, 0, 0, 0);
        step(0, 0, 4'h7, 0, 1, 0);
        step(0, 0, 4'h8, 0, 2, 0);
        chk("gate_changed", 32'(bus.changed), 32'd0);
        step(0, 1, 4'h4, 0, 0, 0);
        chk("reen_fell", 32'(bus.fell), 32'h1);

        // Saturation and clear priority
        step(0, 0, 4'h4, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 4'h4, 0, 1, 0);
        chk("sat_stable_cnt", 32'(bus.stable_cnt), 32'd3);
        step(0, 1, 4'h5, 0, 0, 1);
        chk("clr_rose", 32'(bus.rose), 32'h1);
        chk("clr_rise_cnt", 32'(bus.rise_cnt), 32'd0);

        // Mid-run reset with full history
        step(1, 1, 4'hA, 0, 3, 0);
        chk("mid_rst_valid", 32'(bus.past_valid), 32'd0);
        step(0, 1, 4'hF, 0, 0, 0);
        chk("mid_rst_rose", 32'(bus.rose), 32'h0);

        // Random mixed traffic, including mon_bit and past_sel changes
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 2'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_history_monitor.md
# edge_history_monitor

Synthesizable, parametrised sampled-value monitor for the SVA study benches. It is the RTL equivalent of `$sampled`, `$rose`, `$fell`, `$changed`, `$stable` and `$past(x,N)` on a WIDTH-bit bus. It also keeps saturating event counters and a stable-run counter. It sits beside a DUT in a bench, or inside a design, so that assertion results can be cross-checked against registered hardware flags cycle by cycle.

## Interface
- WIDTH, 4, width of monitored bus `din`
- DEPTH, 4, number of past samples retained (DEPTH ≥ 2)
- CNT_W, 8, width of the event and stable-run counters
- clk  input  1  clock; all sampling on posedge
- rst  input  1  reset, synchronous, active-high
- en  input  1  sample enable; a sample is taken only on posedges with en=1
- din  input  WIDTH  monitored bus
- mon_bit  input  $clog2(WIDTH)  bit index counted by rise_cnt/fall_cnt
- past_sel  input  $clog2(DEPTH)  history tap: 0 = latest sample, k = k samples earlier
- clr_cnt  input  1  synchronous clear of rise_cnt, fall_cnt and stable_cnt
- rose  output  WIDTH  per-bit rising edge between the last two samples
- fell  output  WIDTH  per-bit falling edge between the last two samples
- changed  output  1  any bit differs between the last two samples
- stable  output  1  last two samples identical
- past_val  output  WIDTH  hist[past_sel]
- past_valid  output  1  history holds at least past_sel+1 samples
- stable_cnt  output  CNT_W  consecutive samples equal to their predecessor, saturating
- rise_cnt  output  CNT_W  rising edges seen on din[mon_bit], saturating
- fall_cnt  output  CNT_W  falling edges seen on din[mon_bit], saturating

## Operation
- History is a shift register hist[0..DEPTH-1] with fill counter `fill` (0..DEPTH).
  - On a sample: hist[0] <= din, hist[i] <= hist[i-1], fill <= min(fill+1, DEPTH).
- `primed` = fill ≥ 1 before the current sample. Edge logic compares the new din against the old hist[0] only when primed.
- On a primed sample, all outputs are registered:
  - rose <= din & ~hist[0]
  - fell <= ~din & hist[0]
  - changed <= (din != hist[0])
  - stable <= (din == hist[0])
- On an unprimed sample (the first sample after reset): rose=fell=0, changed=0, stable=0. Past-before-reset is undefined and never reported as an edge.
- On a posedge with en=0: rose, fell, changed and stable clear to 0 (they are single-sample pulses). hist, fill and all counters hold.
- stable_cnt:
  - Primed sample with changed → 0.
  - Primed sample with stable → +1, saturating at 2^CNT_W−1.
- rise_cnt / fall_cnt: +1 when the registered rose[mon_bit] / fell[mon_bit] condition is true for this sample; saturate at 2^CNT_W−1.
  - mon_bit is sampled on the same edge.
  - A mon_bit change affects only later samples; counts are never re-evaluated.
- clr_cnt=1 forces all three counters to 0 on that edge. It takes priority over any increment on the same edge. It does not touch history or flags.
- past_val and past_valid are combinational from the registered hist/fill and past_sel:
  - past_val = hist[past_sel]
  - past_valid = (fill > past_sel)
  - past_val returns 0 while not valid.
- past_sel ≥ DEPTH (non-power-of-2 DEPTH): past_val=0, past_valid=0.

## Timing
- Reset (rst=1 at posedge): hist all 0, fill=0, and every output 0 (rose, fell, changed, stable, past_val, past_valid, all counters). rst has priority over en and clr_cnt.
- Latency: flags and counters reflect the sample taken at posedge k, visible immediately after posedge k, stable until posedge k+1.
  - This matches `$fell` evaluated in the clocking event of posedge k.
- din is sampled with pre-edge values; changes coincident with the edge belong to the next sample.
- Reset asserted mid-run: all state is lost. The next sample is unprimed and produces no edge.
- Counter saturation: the value holds at all-ones; edge flags still pulse.
- A 1→0→1 glitch between two enabled edges is invisible by design.

## Test plan
- Reset then bit toggle: rst 2 cycles, en=1, din bit0 sequence 0,1,1,0 on successive edges.
  - After edge 1: rose=0, fell=0 (unprimed).
  - Edge 2: rose=0001, rise_cnt=1.
  - Edge 3: stable=1, stable_cnt=1.
  - Edge 4: fell=0001, fall_cnt=1, stable_cnt=0.
- Alternating bus: din alternates 4'b0100 and 4'b0101 for 6 edges, mon_bit=0.
  - rose and fell alternate 0001 and 0000; changed=1 every primed edge.
  - Final rise_cnt=3, fall_cnt=2.
  - Bit2 never flags.
- History taps: feed 1,2,3,4,5 with DEPTH=4.
  - past_sel=3 → past_valid=0 until the 4th sample, then past_val=2 after the 5th.
  - past_sel=0 → 5.
- Enable gating: en=0 for 3 edges while din changes.
  - Flags are 0 and counters/history are unchanged.
  - On re-enable, the edge is computed against the last enabled sample.
- Saturation and clear: CNT_W=2, hold din constant for 6 samples → stable_cnt stops at 3.
  - clr_cnt asserted with a simultaneous rise → rise_cnt=0 after that edge.
- Mid-run reset: rst pulsed with fill=4 → all outputs 0, past_valid=0.
  - The next sample with din≠0 gives rose=0.
